// File: rtl/vga_host_regs_pkg.sv
// vga_host_regs_pkg: shared register map, control bit indices and FSM state type for the VGA text host interface
package vga_host_regs_pkg;
    localparam int          CHARS_DEF      = 2000;
    localparam logic [7:0]  CTRL_RST_DEF   = 8'h01;
    localparam logic [7:0]  REG_STATUS     = 8'h00;
    localparam logic [7:0]  REG_DATA       = 8'h01;
    localparam logic [7:0]  REG_CUR_AL     = 8'h02;
    localparam logic [7:0]  REG_CUR_AH     = 8'h03;
    localparam logic [7:0]  REG_CONTROL    = 8'h04;
    localparam int          CTRL_CURSOR_EN = 0;
    localparam int          CTRL_BLINK_EN  = 1;
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_VRAM_WAIT,
        S_DONE
    } state_t;
endpackage

// File: rtl/vga_cursor_ctr.sv
// vga_cursor_ctr: 11-bit cursor counter with clamped load, wrapping increment and sticky wrap flag
module vga_cursor_ctr #(
    parameter int CHARS = 2000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [10:0] i_load_val,
    input  logic        i_inc,
    input  logic        i_clr_wrap,
    output logic [10:0] o_cnt,
    output logic        o_wrap
);
    localparam logic [10:0] LAST = 11'(CHARS - 1);
    logic [10:0] r_cnt;
    logic        r_wrap;
    // Load wins over increment; the wrap flag is set on rollover and cleared on request
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            if (i_load)
                r_cnt <= (i_load_val > LAST) ? LAST : i_load_val;
            else if (i_inc)
                r_cnt <= (r_cnt == LAST) ? 11'd0 : r_cnt + 11'd1;
            if (i_inc && !i_load && r_cnt == LAST)
                r_wrap <= 1'b1;
            else if (i_clr_wrap)
                r_wrap <= 1'b0;
        end
    end
    assign o_cnt  = r_cnt;
    assign o_wrap = r_wrap;
endmodule

// File: rtl/vga_host_regs.sv
// vga_host_regs: host register responder; decodes one command per strobe, writes VRAM at the cursor and advances it
module vga_host_regs
    import vga_host_regs_pkg::*;
#(
    parameter int         CHARS    = CHARS_DEF,
    parameter logic [7:0] CTRL_RST = CTRL_RST_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_cmd,
    input  logic [10:0] i_cursor_adr,
    input  logic [7:0]  i_port,
    input  logic        i_cs_h,
    input  logic        i_rl_wh,
    output logic        o_ready_h,
    output logic [7:0]  o_port_rd,
    output logic        o_vram_we,
    output logic [10:0] o_vram_adr,
    output logic [7:0]  o_vram_data,
    input  logic        i_vram_ack,
    output logic [10:0] o_cursor_adr,
    output logic        o_cursor_en,
    output logic        o_blink_en
);
    state_t      r_state;
    logic        r_ready;
    logic [7:0]  r_port_rd;
    logic        r_we;
    logic [10:0] r_vadr;
    logic [7:0]  r_vdata;
    logic [7:0]  r_ctrl;
    logic [7:0]  r_last;
    logic [7:0]  r_cmd;
    logic        r_rw;
    logic [7:0]  r_port;
    logic [10:0] r_cadr;
    logic [10:0] w_cursor;
    logic        w_wrap;
    logic        w_load;
    logic [10:0] w_load_val;
    logic        w_inc;
    logic        w_clr_wrap;
    logic [7:0]  w_rd;

    // Cursor counter controls: register loads and status clear happen in EXEC, increment on VRAM grant
    always_comb begin
        w_load     = r_state == S_EXEC && r_rw && (r_cmd == REG_CUR_AL || r_cmd == REG_CUR_AH);
        w_load_val = (r_cmd == REG_CUR_AL) ? {w_cursor[10:8], r_port} : r_cadr;
        w_inc      = r_state == S_VRAM_WAIT && i_vram_ack;
        w_clr_wrap = r_state == S_EXEC && !r_rw && r_cmd == REG_STATUS;
    end

    // Read data mux for the latched command
    always_comb begin
        w_rd = (r_cmd == REG_STATUS)  ? {6'b0, w_wrap, r_ctrl[CTRL_CURSOR_EN]} :
               (r_cmd == REG_DATA)    ? r_last :
               (r_cmd == REG_CUR_AL)  ? w_cursor[7:0] :
               (r_cmd == REG_CUR_AH)  ? {5'b0, w_cursor[10:8]} :
               (r_cmd == REG_CONTROL) ? r_ctrl : 8'h00;
    end

    vga_cursor_ctr #(.CHARS(CHARS)) u_cursor (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_inc      (w_inc),
        .i_clr_wrap (w_clr_wrap),
        .o_cnt      (w_cursor),
        .o_wrap     (w_wrap)
    );

    // Command FSM with registered handshake, read data and VRAM request outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_port_rd <= '0;
            r_we      <= 1'b0;
            r_vadr    <= '0;
            r_vdata   <= '0;
            r_ctrl    <= CTRL_RST;
            r_last    <= '0;
            r_cmd     <= '0;
            r_rw      <= 1'b0;
            r_port    <= '0;
            r_cadr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_cs_h) begin
                    r_cmd   <= i_cmd;
                    r_rw    <= i_rl_wh;
                    r_port  <= i_port;
                    r_cadr  <= i_cursor_adr;
                    r_ready <= 1'b0;
                    if (i_cmd == REG_DATA && i_rl_wh) begin
                        r_we    <= 1'b1;
                        r_vadr  <= w_cursor;
                        r_vdata <= i_port;
                        r_state <= S_VRAM_WAIT;
                    end else
                        r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_rw && r_cmd == REG_CONTROL)
                        r_ctrl <= r_port;
                    if (!r_rw)
                        r_port_rd <= w_rd;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_VRAM_WAIT: if (i_vram_ack) begin
                    r_we    <= 1'b0;
                    r_ready <= 1'b1;
                    r_last  <= r_vdata;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready_h    = r_ready;
    assign o_port_rd    = r_port_rd;
    assign o_vram_we    = r_we;
    assign o_vram_adr   = r_vadr;
    assign o_vram_data  = r_vdata;
    assign o_cursor_adr = w_cursor;
    assign o_cursor_en  = r_ctrl[CTRL_CURSOR_EN];
    assign o_blink_en   = r_ctrl[CTRL_BLINK_EN];
endmodule

// File: tb/tb_vga_host_regs.sv
// tb_vga_host_regs: directed and randomized checks of the host register responder against a register-level model
module tb_vga_host_regs;
    localparam int CHARS = 2000;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_cmd = '0;
    logic [10:0] i_cursor_adr = '0;
    logic [7:0]  i_port = '0;
    logic        i_cs_h = 1'b0;
    logic        i_rl_wh = 1'b0;
    logic        o_ready_h;
    logic [7:0]  o_port_rd;
    logic        o_vram_we;
    logic [10:0] o_vram_adr;
    logic [7:0]  o_vram_data;
    logic        i_vram_ack = 1'b0;
    logic [10:0] o_cursor_adr;
    logic        o_cursor_en;
    logic        o_blink_en;
    int checks = 0;
    int failures = 0;
    int m_cur, m_ctrl, m_wrap, m_last;

    always #5 clk = ~clk;

    vga_host_regs dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_cmd        (i_cmd),
        .i_cursor_adr (i_cursor_adr),
        .i_port       (i_port),
        .i_cs_h       (i_cs_h),
        .i_rl_wh      (i_rl_wh),
        .o_ready_h    (o_ready_h),
        .o_port_rd    (o_port_rd),
        .o_vram_we    (o_vram_we),
        .o_vram_adr   (o_vram_adr),
        .o_vram_data  (o_vram_data),
        .i_vram_ack   (i_vram_ack),
        .o_cursor_adr (o_cursor_adr),
        .o_cursor_en  (o_cursor_en),
        .o_blink_en   (o_blink_en)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = 0; m_ctrl = 1; m_wrap = 0; m_last = 0;
    endtask

    task automatic check_state();
        chk("cursor", 32'(o_cursor_adr), m_cur);
        chk("cursor_en", 32'(o_cursor_en), m_ctrl % 2);
        chk("blink_en", 32'(o_blink_en), (m_ctrl / 2) % 2);
    endtask

    task automatic reg_op(input logic [7:0] cmd, input logic rw, input logic [7:0] port, input logic [10:0] cadr);
        int exp_rd;
        @(negedge clk);
        chk("ready_before", 32'(o_ready_h), 1);
        i_cs_h = 1'b1; i_cmd = cmd; i_rl_wh = rw; i_port = port; i_cursor_adr = cadr;
        @(negedge clk);
        i_cs_h = 1'b0; i_cmd = 8'($urandom); i_port = 8'($urandom); i_cursor_adr = 11'($urandom);
        chk("ready_n1", 32'(o_ready_h), 0);
        @(negedge clk);
        chk("ready_n2", 32'(o_ready_h), 0);
        @(negedge clk);
        chk("ready_n3", 32'(o_ready_h), 1);
        if (rw) begin
            if (cmd == 8'h02) m_cur = (m_cur / 256) * 256 + int'(port);
            if (cmd == 8'h03) m_cur = int'(cadr);
            if (m_cur > CHARS - 1) m_cur = CHARS - 1;
            if (cmd == 8'h04) m_ctrl = int'(port);
        end else begin
            exp_rd = (cmd == 8'h00) ? m_wrap * 2 + m_ctrl % 2 :
                     (cmd == 8'h01) ? m_last :
                     (cmd == 8'h02) ? m_cur % 256 :
                     (cmd == 8'h03) ? m_cur / 256 :
                     (cmd == 8'h04) ? m_ctrl : 0;
            chk("port_rd", 32'(o_port_rd), exp_rd);
            if (cmd == 8'h00) m_wrap = 0;
        end
        chk("vram_we_idle", 32'(o_vram_we), 0);
        check_state();
    endtask

    task automatic data_wr(input logic [7:0] port, input int d, input bit glitch);
        @(negedge clk);
        chk("ready_before_wr", 32'(o_ready_h), 1);
        i_cs_h = 1'b1; i_cmd = 8'h01; i_rl_wh = 1'b1; i_port = port;
        @(negedge clk);
        i_cs_h = 1'b0; i_port = 8'($urandom);
        chk("wr_ready_low", 32'(o_ready_h), 0);
        chk("we_rise", 32'(o_vram_we), 1);
        chk("vram_adr", 32'(o_vram_adr), m_cur);
        chk("vram_data", 32'(o_vram_data), 32'(port));
        for (int i = 0; i < d; i++) begin
            if (glitch && i == 0) begin
                i_cs_h = 1'b1; i_cmd = 8'h01; i_rl_wh = 1'b1; i_port = ~port;
            end
            @(negedge clk);
            i_cs_h = 1'b0;
            chk("we_held", 32'(o_vram_we), 1);
            chk("adr_held", 32'(o_vram_adr), m_cur);
            chk("data_held", 32'(o_vram_data), 32'(port));
            chk("ready_held_low", 32'(o_ready_h), 0);
        end
        i_vram_ack = 1'b1;
        @(negedge clk);
        i_vram_ack = 1'b0;
        chk("we_drop", 32'(o_vram_we), 0);
        chk("ready_after_ack", 32'(o_ready_h), 1);
        m_last = int'(port);
        if (m_cur == CHARS - 1) begin
            m_cur = 0; m_wrap = 1;
        end else m_cur++;
        check_state();
        if (glitch) begin
            @(negedge clk);
            chk("no_second_write", 32'(o_vram_we), 0);
            chk("cursor_once", 32'(o_cursor_adr), m_cur);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        chk("rst_ready", 32'(o_ready_h), 1);
        chk("rst_port_rd", 32'(o_port_rd), 0);
        chk("rst_we", 32'(o_vram_we), 0);
        chk("rst_adr", 32'(o_vram_adr), 0);
        chk("rst_data", 32'(o_vram_data), 0);
        check_state();
        // cursor high write, ready low exactly two cycles
        reg_op(8'h03, 1'b1, 8'h00, 11'h123);
        chk("t1_cursor", 32'(o_cursor_adr), 32'h123);
        // last cell write with late ack, wrap, status read twice
        reg_op(8'h03, 1'b1, 8'h00, 11'd1999);
        data_wr(8'h41, 2, 1'b0);
        chk("t2_wrapped", 32'(o_cursor_adr), 0);
        reg_op(8'h00, 1'b0, 8'h00, 11'h0);
        chk("t2_status1", 32'(o_port_rd), 32'h03);
        reg_op(8'h00, 1'b0, 8'h00, 11'h0);
        chk("t2_status2", 32'(o_port_rd), 32'h01);
        // initiator-style fill of 256 cells with same-cycle ack
        reg_op(8'h03, 1'b1, 8'h00, 11'h0);
        for (int i = 0; i < 256; i++) data_wr(8'(i), 0, 1'b0);
        chk("t3_cursor", 32'(o_cursor_adr), 256);
        reg_op(8'h03, 1'b0, 8'h00, 11'h0);
        chk("t3_cur_ah", 32'(o_port_rd), 32'h01);
        // control register and unknown command
        reg_op(8'h04, 1'b1, 8'h02, 11'h0);
        chk("t4_cursor_en", 32'(o_cursor_en), 0);
        chk("t4_blink_en", 32'(o_blink_en), 1);
        reg_op(8'h04, 1'b0, 8'h00, 11'h0);
        chk("t4_ctrl_rd", 32'(o_port_rd), 32'h02);
        reg_op(8'h07, 1'b0, 8'h00, 11'h0);
        chk("t4_unknown", 32'(o_port_rd), 32'h00);
        // clamp through the low byte
        reg_op(8'h03, 1'b1, 8'h00, 11'h7C0);
        reg_op(8'h02, 1'b1, 8'hFF, 11'h0);
        chk("clamp_lo", 32'(o_cursor_adr), CHARS - 1);
        reg_op(8'h03, 1'b1, 8'h00, 11'h7FF);
        chk("clamp_hi", 32'(o_cursor_adr), CHARS - 1);
        // strobe during VRAM wait is ignored
        reg_op(8'h03, 1'b1, 8'h00, 11'd500);
        data_wr(8'h55, 3, 1'b1);
        // stray ack while idle is ignored
        @(negedge clk);
        i_vram_ack = 1'b1;
        @(negedge clk);
        i_vram_ack = 1'b0;
        chk("stray_ack", 32'(o_cursor_adr), m_cur);
        // randomized commands against the model
        for (int n = 0; n < 120; n++) begin
            logic [7:0] c;
            logic w;
            c = 8'($urandom_range(0, 7));
            w = 1'($urandom);
            if (c == 8'h01 && w) data_wr(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
            else reg_op(c, w, 8'($urandom), 11'($urandom));
        end
        // reset during VRAM wait drops the write
        reg_op(8'h04, 1'b1, 8'h03, 11'h0);
        @(negedge clk);
        i_cs_h = 1'b1; i_cmd = 8'h01; i_rl_wh = 1'b1; i_port = 8'h77;
        @(negedge clk);
        i_cs_h = 1'b0;
        chk("t6_we_pending", 32'(o_vram_we), 1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        model_reset();
        chk("t6_we", 32'(o_vram_we), 0);
        chk("t6_ready", 32'(o_ready_h), 1);
        chk("t6_port_rd", 32'(o_port_rd), 0);
        check_state();
        reg_op(8'h04, 1'b0, 8'h00, 11'h0);
        chk("t6_ctrl", 32'(o_port_rd), 32'h01);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
